// File: rtl/rob_commit_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rob_commit_queue
//
// Reorder buffer for the out-of-order core. The dispatcher allocates one entry
// per instruction in program order. The CDB marks entries ready with their
// results. Entries retire in order, at most one per cycle, and each retirement
// produces a one-cycle pulse on the register-file commit port. A retiring
// branch whose actual outcome differs from its prediction also pulses
// rollback_flag with the corrected PC and empties the whole buffer.
//
// Entry ids seen outside the buffer are slot index + 1. Id 0 is reserved as
// "no dependency", so it never matches a slot.
//
// Optional feature (macro ROB_QRY_BYPASS_EN):
//   defined   : an operand query also sees a same-cycle CDB broadcast to a
//               busy entry (qry_ready/qry_val forwarded from cdb_*).
//   undefined : a query sees stored state only; a result becomes visible the
//               cycle after its CDB broadcast.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   alloc_en/rd/is_br/pred_taken
//                     dispatcher allocation request (ignored while full)
//   alloc_id          id the next allocation receives (combinational)
//   full              buffer holds ROB_SIZE entries (combinational)
//   cdb_en/id/val/taken/target
//                     result broadcast; ignored for id 0 or non-busy entries
//   qry_id            operand lookup id
//   qry_ready/qry_val lookup result (0/0 unless the entry holds a result)
//   commit_flag/rd/id/val
//                     registered one-cycle retirement pulse
//   rollback_flag/pc  registered one-cycle flush pulse and redirect PC
// -----------------------------------------------------------------------------
module rob_commit_queue #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W     = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  // dispatcher allocation
  input  logic              alloc_en,
  input  logic [4:0]        alloc_rd,
  input  logic              alloc_is_br,
  input  logic              alloc_pred_taken,
  output logic [ID_W-1:0]   alloc_id,
  output logic              full,
  // common data bus
  input  logic              cdb_en,
  input  logic [ID_W-1:0]   cdb_id,
  input  logic [DATA_W-1:0] cdb_val,
  input  logic              cdb_taken,
  input  logic [DATA_W-1:0] cdb_target,
  // operand query
  input  logic [ID_W-1:0]   qry_id,
  output logic              qry_ready,
  output logic [DATA_W-1:0] qry_val,
  // register-file commit port
  output logic              commit_flag,
  output logic [4:0]        commit_rd,
  output logic [ID_W-1:0]   commit_id,
  output logic [DATA_W-1:0] commit_val,
  // flush
  output logic              rollback_flag,
  output logic [DATA_W-1:0] rollback_pc
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] SIZE_CNT = CNT_W'(ROB_SIZE);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]    head_q, head_d;
  logic [IDX_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;

  // Entry payload. Only busy/ready carry meaning after reset or flush, so the
  // payload is never reset.
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [DATA_W-1:0]   val_q    [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];
  logic [ROB_SIZE-1:0] is_br_q;
  logic [ROB_SIZE-1:0] pred_q;
  logic [ROB_SIZE-1:0] taken_q;

  // Registered outputs
  logic              commit_flag_q;
  logic [4:0]        commit_rd_q;
  logic [ID_W-1:0]   commit_id_q;
  logic [DATA_W-1:0] commit_val_q;
  logic              rollback_flag_q;
  logic [DATA_W-1:0] rollback_pc_q;

  // ---------------------------------------------------------------------------
  // Per-entry id decode. A CDB write or query only selects a slot that is
  // busy; ids 0 and ids beyond ROB_SIZE never match any slot.
  // ---------------------------------------------------------------------------
  logic [ROB_SIZE-1:0] cdb_sel;
  logic [ROB_SIZE-1:0] qry_sel;

  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      localparam logic [ID_W-1:0] ENTRY_ID = ID_W'(gi + 1);
      assign cdb_sel[gi] = cdb_en && (cdb_id == ENTRY_ID) && busy_q[gi];
      assign qry_sel[gi] = (qry_id == ENTRY_ID) && busy_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control decisions for this cycle
  // ---------------------------------------------------------------------------
  logic full_w;
  logic alloc_ok;
  logic commit_fire;
  logic mispredict;

  assign full_w   = (count_q == SIZE_CNT);
  assign alloc_ok = alloc_en && !full_w;

  // Retirement looks only at registered ready, so a CDB to the head entry
  // this cycle cannot retire it until the following edge.
  assign commit_fire = busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && is_br_q[head_q] &&
                       (taken_q[head_q] != pred_q[head_q]);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q | cdb_sel;

    if (commit_fire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end

    // The tail slot is never busy when alloc_ok, so it cannot collide with
    // the retiring head or with a CDB write.
    if (alloc_ok) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + IDX_W'(1);
    end

    unique case ({alloc_ok, commit_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A mispredicted retirement empties the buffer; it overrides any
    // same-cycle allocation and CDB write.
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      ready_q         <= '0;
      commit_flag_q   <= 1'b0;
      commit_rd_q     <= '0;
      commit_id_q     <= '0;
      commit_val_q    <= '0;
      rollback_flag_q <= 1'b0;
      rollback_pc_q   <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      commit_flag_q   <= commit_fire;
      commit_rd_q     <= commit_fire ? rd_q[head_q] : '0;
      commit_id_q     <= commit_fire ? (ID_W'(head_q) + ID_W'(1)) : '0;
      commit_val_q    <= commit_fire ? val_q[head_q] : '0;
      rollback_flag_q <= mispredict;
      rollback_pc_q   <= mispredict ? target_q[head_q] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload writes. Writes that coincide with a flush or reset land in
  // slots that end up non-busy, so they are harmless.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      rd_q[tail_q]    <= alloc_rd;
      is_br_q[tail_q] <= alloc_is_br;
      pred_q[tail_q]  <= alloc_pred_taken;
    end
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (cdb_sel[i]) begin
        val_q[i]    <= cdb_val;
        taken_q[i]  <= cdb_taken;
        target_q[i] <= cdb_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand query
  // ---------------------------------------------------------------------------
  always_comb begin
    qry_ready = 1'b0;
    qry_val   = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (qry_sel[i] && ready_q[i]) begin
        qry_ready = 1'b1;
        qry_val   = val_q[i];
      end
    end
`ifdef ROB_QRY_BYPASS_EN
    // Forward a result being broadcast this cycle to a busy queried entry.
    if (cdb_en && (cdb_id == qry_id) && (|qry_sel)) begin
      qry_ready = 1'b1;
      qry_val   = cdb_val;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign alloc_id      = ID_W'(tail_q) + ID_W'(1);
  assign full          = full_w;
  assign commit_flag   = commit_flag_q;
  assign commit_rd     = commit_rd_q;
  assign commit_id     = commit_id_q;
  assign commit_val    = commit_val_q;
  assign rollback_flag = rollback_flag_q;
  assign rollback_pc   = rollback_pc_q;

endmodule

// File: tb/tb_rob_commit_queue.sv
`timescale 1ns/1ps
// Directed testbench for rob_commit_queue (ROB_SIZE 16, ID_W 5, DATA_W 32).
module tb_rob_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic        alloc_is_br;
  logic        alloc_pred_taken;
  logic [4:0]  alloc_id;
  logic        full;
  logic        cdb_en;
  logic [4:0]  cdb_id;
  logic [31:0] cdb_val;
  logic        cdb_taken;
  logic [31:0] cdb_target;
  logic [4:0]  qry_id;
  logic        qry_ready;
  logic [31:0] qry_val;
  logic        commit_flag;
  logic [4:0]  commit_rd;
  logic [4:0]  commit_id;
  logic [31:0] commit_val;
  logic        rollback_flag;
  logic [31:0] rollback_pc;

  int checks = 0;
  int errors = 0;

  rob_commit_queue #(.ROB_SIZE(16), .ID_W(5), .DATA_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_en         (alloc_en),
    .alloc_rd         (alloc_rd),
    .alloc_is_br      (alloc_is_br),
    .alloc_pred_taken (alloc_pred_taken),
    .alloc_id         (alloc_id),
    .full             (full),
    .cdb_en           (cdb_en),
    .cdb_id           (cdb_id),
    .cdb_val          (cdb_val),
    .cdb_taken        (cdb_taken),
    .cdb_target       (cdb_target),
    .qry_id           (qry_id),
    .qry_ready        (qry_ready),
    .qry_val          (qry_val),
    .commit_flag      (commit_flag),
    .commit_rd        (commit_rd),
    .commit_id        (commit_id),
    .commit_val       (commit_val),
    .rollback_flag    (rollback_flag),
    .rollback_pc      (rollback_pc)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only; checks live in the test tasks)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alloc_en         = 1'b0;
    alloc_rd         = '0;
    alloc_is_br      = 1'b0;
    alloc_pred_taken = 1'b0;
    cdb_en           = 1'b0;
    cdb_id           = '0;
    cdb_val          = '0;
    cdb_taken        = 1'b0;
    cdb_target       = '0;
    qry_id           = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic br, input logic pred);
    alloc_en         = 1'b1;
    alloc_rd         = rd;
    alloc_is_br      = br;
    alloc_pred_taken = pred;
    $display("alloc  id=%0d rd=%0d br=%0b pred=%0b full=%0b", alloc_id, rd, br, pred, full);
    tick();
    alloc_en         = 1'b0;
    alloc_is_br      = 1'b0;
    alloc_pred_taken = 1'b0;
  endtask

  task automatic do_cdb(input logic [4:0] id, input logic [31:0] val,
                        input logic taken, input logic [31:0] target);
    cdb_en     = 1'b1;
    cdb_id     = id;
    cdb_val    = val;
    cdb_taken  = taken;
    cdb_target = target;
    $display("cdb    id=%0d val=%h taken=%0b target=%h", id, val, taken, target);
    tick();
    cdb_en     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    qry_id = 5'd1;
    #1;
    checks++;
    if ({commit_flag, commit_rd, commit_id, commit_val} !== 43'd0) begin
      errors++;
      $display("FAIL reset_commit got %h want 0", {commit_flag, commit_rd, commit_id, commit_val});
    end
    checks++;
    if ({rollback_flag, rollback_pc} !== 33'd0) begin
      errors++;
      $display("FAIL reset_rollback got %h want 0", {rollback_flag, rollback_pc});
    end
    checks++;
    if ({full, alloc_id} !== {1'b0, 5'd1}) begin
      errors++;
      $display("FAIL reset_full_allocid got full=%0b id=%0d want full=0 id=1", full, alloc_id);
    end
    checks++;
    if ({qry_ready, qry_val} !== 33'd0) begin
      errors++;
      $display("FAIL reset_query got rdy=%0b val=%h want 0/0", qry_ready, qry_val);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (alloc_id !== 5'(i + 1)) begin
        errors++;
        $display("FAIL fill_alloc_id got %0d want %0d", alloc_id, i + 1);
      end
      do_alloc(5'(i + 1), 1'b0, 1'b0);
    end
    checks++;
    if ({full, alloc_id} !== {1'b1, 5'd1}) begin
      errors++;
      $display("FAIL fill_full got full=%0b id=%0d want full=1 id=1", full, alloc_id);
    end
    // A 17th allocation must be ignored.
    do_alloc(5'd9, 1'b0, 1'b0);
    checks++;
    if ({full, alloc_id, commit_flag} !== {1'b1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL fill_overflow got full=%0b id=%0d cf=%0b want 1/1/0", full, alloc_id, commit_flag);
    end
    // full stays up until the commit lands.
    do_cdb(5'd1, 32'h1111, 1'b0, 32'h0);
    checks++;
    if ({full, commit_flag} !== 2'b10) begin
      errors++;
      $display("FAIL fill_full_before_commit got full=%0b cf=%0b want 1/0", full, commit_flag);
    end
    tick();
    checks++;
    if ({full, commit_flag, commit_id, commit_rd} !== {1'b0, 1'b1, 5'd1, 5'd1}) begin
      errors++;
      $display("FAIL fill_full_drop got full=%0b cf=%0b id=%0d rd=%0d want 0/1/1/1",
               full, commit_flag, commit_id, commit_rd);
    end
    $display("test_fill done");
  endtask

  task automatic test_single_commit();
    do_reset();
    do_alloc(5'd5, 1'b0, 1'b0);
    qry_id = 5'd1;
    #1;
    checks++;
    if (qry_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_qry_pending got rdy=%0b want 0", qry_ready);
    end
    do_cdb(5'd1, 32'hDEAD, 1'b0, 32'h0);
    checks++;
    if (commit_flag !== 1'b0) begin
      errors++;
      $display("FAIL single_no_early_commit got cf=%0b want 0", commit_flag);
    end
    tick();
    checks++;
    if ({commit_flag, commit_rd, commit_id, commit_val} !== {1'b1, 5'd5, 5'd1, 32'hDEAD}) begin
      errors++;
      $display("FAIL single_commit got cf=%0b rd=%0d id=%0d val=%h want 1/5/1/0000dead",
               commit_flag, commit_rd, commit_id, commit_val);
    end
    tick();
    checks++;
    if (commit_flag !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_end got cf=%0b want 0", commit_flag);
    end
    $display("test_single_commit done");
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 1; i <= 3; i++) do_alloc(5'(i), 1'b0, 1'b0);
    do_cdb(5'd3, 32'd33, 1'b0, 32'h0);
    do_cdb(5'd2, 32'd22, 1'b0, 32'h0);
    checks++;
    if (commit_flag !== 1'b0) begin
      errors++;
      $display("FAIL ooo_head_blocks got cf=%0b want 0", commit_flag);
    end
    do_cdb(5'd1, 32'd11, 1'b0, 32'h0);
    checks++;
    if (commit_flag !== 1'b0) begin
      errors++;
      $display("FAIL ooo_no_same_cycle got cf=%0b want 0", commit_flag);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({commit_flag, commit_id, commit_rd, commit_val} !== {1'b1, 5'(k), 5'(k), 32'(11 * k)}) begin
        errors++;
        $display("FAIL ooo_commit_%0d got cf=%0b id=%0d rd=%0d val=%0d want 1/%0d/%0d/%0d",
                 k, commit_flag, commit_id, commit_rd, commit_val, k, k, 11 * k);
      end
    end
    tick();
    checks++;
    if (commit_flag !== 1'b0) begin
      errors++;
      $display("FAIL ooo_idle got cf=%0b want 0", commit_flag);
    end
    $display("test_out_of_order done");
  endtask

  task automatic test_mispredict();
    do_reset();
    do_alloc(5'd7, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) do_alloc(5'(i), 1'b0, 1'b0);
    do_cdb(5'd1, 32'h44, 1'b1, 32'h100);
    // Flush cycle: a same-cycle alloc and CDB must both be dropped.
    alloc_en = 1'b1;
    alloc_rd = 5'd3;
    cdb_en   = 1'b1;
    cdb_id   = 5'd2;
    cdb_val  = 32'h5;
    tick();
    drive_idle();
    qry_id = 5'd2;
    #1;
    checks++;
    if ({commit_flag, commit_id, commit_rd, commit_val} !== {1'b1, 5'd1, 5'd7, 32'h44}) begin
      errors++;
      $display("FAIL mp_commit got cf=%0b id=%0d rd=%0d val=%h want 1/1/7/44",
               commit_flag, commit_id, commit_rd, commit_val);
    end
    checks++;
    if ({rollback_flag, rollback_pc} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL mp_rollback got rf=%0b pc=%h want 1/100", rollback_flag, rollback_pc);
    end
    checks++;
    if ({alloc_id, full, qry_ready} !== {5'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mp_flushed got id=%0d full=%0b qry=%0b want 1/0/0", alloc_id, full, qry_ready);
    end
    tick();
    checks++;
    if ({rollback_flag, commit_flag, rollback_pc} !== 34'd0) begin
      errors++;
      $display("FAIL mp_pulse_end got rf=%0b cf=%0b pc=%h want 0/0/0", rollback_flag, commit_flag, rollback_pc);
    end
    // Buffer restarts empty at id 1.
    do_alloc(5'd12, 1'b0, 1'b0);
    do_cdb(5'd1, 32'h99, 1'b0, 32'h0);
    tick();
    checks++;
    if ({commit_flag, commit_id, commit_rd, alloc_id} !== {1'b1, 5'd1, 5'd12, 5'd2}) begin
      errors++;
      $display("FAIL mp_restart got cf=%0b id=%0d rd=%0d next=%0d want 1/1/12/2",
               commit_flag, commit_id, commit_rd, alloc_id);
    end
    $display("test_mispredict done");
  endtask

  task automatic test_correct_branch();
    do_reset();
    do_alloc(5'd9, 1'b1, 1'b1);
    do_cdb(5'd1, 32'h55, 1'b1, 32'h200);
    tick();
    checks++;
    if ({commit_flag, rollback_flag, rollback_pc} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL br_correct got cf=%0b rf=%0b pc=%h want 1/0/0", commit_flag, rollback_flag, rollback_pc);
    end
    $display("test_correct_branch done");
  endtask

  task automatic test_wrap();
    int ids [12];
    logic [4:0] exp_rd;
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 1'b0, 1'b0);
    // Drain ids 1..10; each commit trails its CDB by one edge.
    for (int k = 1; k <= 10; k++) begin
      do_cdb(5'(k), 32'(k * 16), 1'b0, 32'h0);
      if (k > 1) begin
        checks++;
        if ({commit_flag, commit_id, commit_val} !== {1'b1, 5'(k - 1), 32'((k - 1) * 16)}) begin
          errors++;
          $display("FAIL wrap_drain_%0d got cf=%0b id=%0d val=%h", k - 1, commit_flag, commit_id, commit_val);
        end
      end
    end
    tick();
    checks++;
    if ({commit_flag, commit_id, commit_val} !== {1'b1, 5'd10, 32'd160}) begin
      errors++;
      $display("FAIL wrap_drain_10 got cf=%0b id=%0d val=%h", commit_flag, commit_id, commit_val);
    end
    // Six allocations wrap the tail to slots 0..5 (ids 1..6).
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (alloc_id !== 5'(j + 1)) begin
        errors++;
        $display("FAIL wrap_alloc_id got %0d want %0d", alloc_id, j + 1);
      end
      do_alloc(5'(21 + j), 1'b0, 1'b0);
    end
    for (int j = 0; j < 12; j++) ids[j] = (j < 6) ? (11 + j) : (j - 5);
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) do_cdb(5'(ids[j]), 32'(256 + ids[j]), 1'b0, 32'h0);
      else tick();
      if (j > 0) begin
        exp_rd = (ids[j - 1] >= 11) ? 5'(ids[j - 1]) : 5'(20 + ids[j - 1]);
        checks++;
        if ({commit_flag, commit_id, commit_rd, commit_val} !==
            {1'b1, 5'(ids[j - 1]), exp_rd, 32'(256 + ids[j - 1])}) begin
          errors++;
          $display("FAIL wrap_commit got cf=%0b id=%0d rd=%0d val=%h want 1/%0d/%0d/%h",
                   commit_flag, commit_id, commit_rd, commit_val, ids[j - 1], exp_rd, 256 + ids[j - 1]);
        end
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_query();
    do_reset();
    do_alloc(5'd1, 1'b0, 1'b0);
    do_alloc(5'd2, 1'b0, 1'b0);
    qry_id  = 5'd2;
    cdb_en  = 1'b1;
    cdb_id  = 5'd2;
    cdb_val = 32'd7;
    #1;
    checks++;
`ifdef ROB_QRY_BYPASS_EN
    if ({qry_ready, qry_val} !== {1'b1, 32'd7}) begin
      errors++;
      $display("FAIL qry_same_cycle got rdy=%0b val=%0d want 1/7", qry_ready, qry_val);
    end
`else
    if ({qry_ready, qry_val} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL qry_same_cycle got rdy=%0b val=%0d want 0/0", qry_ready, qry_val);
    end
`endif
    tick();
    cdb_en = 1'b0;
    #1;
    checks++;
    if ({qry_ready, qry_val} !== {1'b1, 32'd7}) begin
      errors++;
      $display("FAIL qry_next_cycle got rdy=%0b val=%0d want 1/7", qry_ready, qry_val);
    end
    qry_id = 5'd1;
    #1;
    checks++;
    if ({qry_ready, qry_val} !== 33'd0) begin
      errors++;
      $display("FAIL qry_pending got rdy=%0b val=%0d want 0/0", qry_ready, qry_val);
    end
    qry_id = 5'd0;
    #1;
    checks++;
    if ({qry_ready, qry_val} !== 33'd0) begin
      errors++;
      $display("FAIL qry_zero_id got rdy=%0b val=%0d want 0/0", qry_ready, qry_val);
    end
    $display("test_query done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_alloc(5'd3, 1'b0, 1'b0);
    do_alloc(5'd4, 1'b0, 1'b0);
    do_cdb(5'd1, 32'h77, 1'b0, 32'h0);
    // Head would commit at this edge; reset must win over commit/alloc/CDB.
    rst      = 1'b1;
    alloc_en = 1'b1;
    alloc_rd = 5'd8;
    cdb_en   = 1'b1;
    cdb_id   = 5'd2;
    cdb_val  = 32'h88;
    tick();
    rst = 1'b0;
    drive_idle();
    qry_id = 5'd1;
    #1;
    checks++;
    if ({commit_flag, commit_val, rollback_flag} !== 34'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got cf=%0b val=%h rf=%0b want 0", commit_flag, commit_val, rollback_flag);
    end
    checks++;
    if ({alloc_id, full, qry_ready} !== {5'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_state got id=%0d full=%0b qry=%0b want 1/0/0", alloc_id, full, qry_ready);
    end
    tick();
    checks++;
    if (commit_flag !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got cf=%0b want 0", commit_flag);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_fill();
    test_single_commit();
    test_out_of_order();
    test_mispredict();
    test_correct_branch();
    test_wrap();
    test_query();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
